btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_conditioner_if.sv | 11 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/btn_conditioner.sv | 92 +++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// The press FSM state encoding and the counter width helper live here.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // Bits needed to hold the larger of two cycle counts without overflow.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side signal bundle: raw pin in, conditioned level and pulses out.
// master = whatever drives the pin and consumes pulses; slave = the conditioner.
interface btn_conditioner_if;
  logic btn_in;
  logic pressed;
  logic step;
  logic set_pulse;

  modport master (output btn_in, input pressed, input step, input set_pulse);
  modport slave  (input btn_in, output pressed, output step, output set_pulse);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement debounce counter.
// pressed flips only after DEBOUNCE_CYCLES straight cycles of the new level.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             pressed_reg;
  logic [CNT_W-1:0] db_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      pressed_reg <= 1'b0;
      db_cnt_reg  <= '0;
    end else begin
      s1_reg <= btn_in;
      s2_reg <= s1_reg;
      // Any cycle of agreement restarts the count, so short bounces are absorbed.
      if (s2_reg != pressed_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          pressed_reg <= s2_reg;
          db_cnt_reg  <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  assign pressed = pressed_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button front end: emits step on every press and set_pulse once a
// press has been held LONG_PRESS_CYCLES cycles.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int LONG_PRESS_CYCLES = 200
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             pressed_lvl;
  btn_state_e       state_reg,     state_next;
  logic [CNT_W-1:0] hold_cnt_reg,  hold_cnt_next;
  logic             set_pulse_reg, set_pulse_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_in),
    .pressed(pressed_lvl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_cnt_reg  <= '0;
      set_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      set_pulse_reg <= set_pulse_next;
    end
  end

  // hold_cnt counts edges since pressed rose; the IDLE edge is the first one.
  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    set_pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pressed_lvl) begin
          hold_cnt_next = HOLD_ONE;
          if (HOLD_ONE >= HOLD_MAX) begin
            set_pulse_next = 1'b1;
            state_next     = HELD;
          end else begin
            state_next = PRESSED;
          end
        end
      end
      PRESSED: begin
        if (!pressed_lvl) begin
          state_next = IDLE;
        end else begin
          if (hold_cnt_reg < HOLD_MAX) begin
            hold_cnt_next = hold_cnt_reg + HOLD_ONE;
          end
          if (hold_cnt_reg >= HOLD_LAST) begin
            set_pulse_next = 1'b1;
            state_next     = HELD;
          end
        end
      end
      HELD: begin
        if (!pressed_lvl) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // pressed is high while still in IDLE only during the cycle right after it
  // rose, so decoding both flops gives a one-cycle step aligned with the rise.
  assign bus.pressed   = pressed_lvl;
  assign bus.step      = pressed_lvl && (state_reg == IDLE);
  assign bus.set_pulse = set_pulse_reg;

endmodule
